// File: rtl/debounce_pkg.sv
// Shared limits and helpers for the multi-channel push-button debouncer.
package debounce_pkg;

   localparam int unsigned DB_MAX_CH     = 32;
   localparam int unsigned DB_MAX_STABLE = 255;

   // Width that holds 0..stable_cnt
   function automatic int unsigned db_cnt_width(input int unsigned stable_cnt);
      return $clog2(stable_cnt + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button channel: optional 2-flop synchroniser, sample counter, level and edge pulses.
// Synchroniser present when DEBOUNCE_SYNC_EN is defined.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CNT = 4,
   parameter bit          INVERT     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_en,
   input  logic pb_in,
   output logic pb_level,
   output logic pb_press,
   output logic pb_release
);

   localparam int unsigned     CW       = db_cnt_width(STABLE_CNT);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CNT - 1);

   logic          pin_c;
   logic          raw_c;
   logic [CW-1:0] cnt_q,     cnt_d;
   logic          level_q,   level_d;
   logic          press_q,   press_d;
   logic          release_q, release_d;

`ifdef DEBOUNCE_SYNC_EN
   logic [1:0] sync_q;

   // Flops reset to the idle pin level so reset release never looks like a press
   always_ff @(posedge clk) begin
      if (rst) sync_q <= {2{INVERT}};
      else     sync_q <= {sync_q[0], pb_in};
   end

   assign pin_c = sync_q[1];
`else
   assign pin_c = pb_in;
`endif

   assign raw_c = pin_c ^ INVERT;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // Counter is the channel state: zero means stable, nonzero means a change is pending
   always_comb begin
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sample_en) begin
         if (raw_c == level_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            level_d   = raw_c;
            press_d   = raw_c;
            release_d = ~raw_c;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   assign pb_level   = level_q;
   assign pb_press   = press_q;
   assign pb_release = release_q;

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer; each channel runs independently off a shared sampling strobe.
// Define DEBOUNCE_SYNC_EN to add a 2-flop synchroniser on every pb_in bit.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned STABLE_CNT = 4,
   parameter bit          INVERT     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_en,
   input  logic [NUM_CH-1:0] pb_in,
   output logic [NUM_CH-1:0] pb_level,
   output logic [NUM_CH-1:0] pb_press,
   output logic [NUM_CH-1:0] pb_release
);

   if (NUM_CH < 1 || NUM_CH > DB_MAX_CH) begin : g_bad_num_ch
      $error("debounce_multi: NUM_CH out of range");
   end
   if (STABLE_CNT < 1 || STABLE_CNT > DB_MAX_STABLE) begin : g_bad_stable_cnt
      $error("debounce_multi: STABLE_CNT out of range");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CNT (STABLE_CNT),
         .INVERT     (INVERT)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .sample_en  (sample_en),
         .pb_in      (pb_in[i]),
         .pb_level   (pb_level[i]),
         .pb_press   (pb_press[i]),
         .pb_release (pb_release[i])
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: table-driven sample vectors plus latency sweeps.
module tb_debounce_multi;

`ifdef DEBOUNCE_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   typedef struct packed {
      logic [3:0] pb;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       sen;
   logic [3:0] pb, lvl, prs, rel;

   logic       sen_s;
   logic       pb1, lvl1, prs1, rel1;
   logic [7:0] pb8, lvl8, prs8, rel8;

   int n_tests = 0;
   int n_fail  = 0;

   debounce_multi #(.NUM_CH(4), .STABLE_CNT(4), .INVERT(1'b1)) dut (
      .clk(clk), .rst(rst), .sample_en(sen), .pb_in(pb),
      .pb_level(lvl), .pb_press(prs), .pb_release(rel));

   debounce_multi #(.NUM_CH(1), .STABLE_CNT(1), .INVERT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .sample_en(sen_s), .pb_in(pb1),
      .pb_level(lvl1), .pb_press(prs1), .pb_release(rel1));

   debounce_multi #(.NUM_CH(8), .STABLE_CNT(16), .INVERT(1'b1)) dut8 (
      .clk(clk), .rst(rst), .sample_en(sen_s), .pb_in(pb8),
      .pb_level(lvl8), .pb_press(prs8), .pb_release(rel8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] p, input logic [3:0] l,
                               input logic [3:0] pr, input logic [3:0] r);
      vec_t v;
      v.pb = p; v.lvl = l; v.prs = pr; v.rel = r;
      return v;
   endfunction

   // 9 idle clocks (absorbs synchroniser delay), then one strobe; returns #1 after the strobe edge
   task automatic do_sample(input logic [3:0] pbv);
      pb = pbv;
      repeat (9) @(posedge clk);
      #1 sen = 1'b1;
      @(posedge clk);
      #1 sen = 1'b0;
   endtask

   // Continuous-strobe latency measurement on a sweep instance
   task automatic measure(input int which, input logic [7:0] pbv, input logic [7:0] exp_lvl,
                          input logic [7:0] exp_prs, input logic [7:0] exp_rel,
                          input int exp_n, input string nm);
      int         n;
      bit         seen;
      logic [7:0] l, p, r;
      n = 0; seen = 1'b0;
      if (which == 1) pb1 = pbv[0]; else pb8 = pbv;
      while (!seen && n < 100) begin
         @(posedge clk); #1;
         n++;
         l = (which == 1) ? {7'b0, lvl1} : lvl8;
         if (l == exp_lvl) seen = 1'b1;
      end
      p = (which == 1) ? {7'b0, prs1} : prs8;
      r = (which == 1) ? {7'b0, rel1} : rel8;
      check({nm, " latency"}, 32'(n), 32'(exp_n));
      check({nm, " press"}, 32'(p), 32'(exp_prs));
      check({nm, " release"}, 32'(r), 32'(exp_rel));
      @(posedge clk); #1;
      p = (which == 1) ? {7'b0, prs1} : prs8;
      r = (which == 1) ? {7'b0, rel1} : rel8;
      check({nm, " pulse cleared"}, 32'({p, r}), 32'(0));
   endtask

   initial begin
      vec_t vecs[$];

      rst = 1'b1; sen = 1'b0; pb = 4'hF;
      sen_s = 1'b0; pb1 = 1'b1; pb8 = 8'hFF;

      // Clean press ch0
      for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b1110, 4'b0000, 4'b0000, 4'b0000));
      vecs.push_back(mk(4'b1110, 4'b0001, 4'b0001, 4'b0000));
      vecs.push_back(mk(4'b1110, 4'b0001, 4'b0000, 4'b0000));
      vecs.push_back(mk(4'b1110, 4'b0001, 4'b0000, 4'b0000));
      // Bounce ch1: low, low, high, low, low, low, low
      vecs.push_back(mk(4'b1100, 4'b0001, 4'b0000, 4'b0000));
      vecs.push_back(mk(4'b1100, 4'b0001, 4'b0000, 4'b0000));
      vecs.push_back(mk(4'b1110, 4'b0001, 4'b0000, 4'b0000));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b1100, 4'b0001, 4'b0000, 4'b0000));
      vecs.push_back(mk(4'b1100, 4'b0011, 4'b0010, 4'b0000));
      // Press ch2
      for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b1000, 4'b0011, 4'b0000, 4'b0000));
      vecs.push_back(mk(4'b1000, 4'b0111, 4'b0100, 4'b0000));
      // Simultaneous release of ch0 and ch2
      for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b1101, 4'b0111, 4'b0000, 4'b0000));
      vecs.push_back(mk(4'b1101, 4'b0010, 4'b0000, 4'b0101));
      // Release ch1
      for (int i = 0; i < 3; i++) vecs.push_back(mk(4'b1111, 4'b0010, 4'b0000, 4'b0000));
      vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 4'b0010));

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset main outputs", 32'({lvl, prs, rel}), 32'(0));
      check("reset sweep outputs", 32'({lvl1, prs1, rel1, lvl8, prs8, rel8}), 32'(0));
      rst = 1'b0;

      // Idle with released (high) pins
      for (int i = 0; i < 20; i++) begin
         do_sample(4'hF);
         check($sformatf("idle[%0d]", i), 32'({lvl, prs, rel}), 32'(0));
      end

      // Table vectors
      foreach (vecs[i]) begin
         do_sample(vecs[i].pb);
         check($sformatf("vec[%0d] level", i), 32'(lvl), 32'(vecs[i].lvl));
         check($sformatf("vec[%0d] press", i), 32'(prs), 32'(vecs[i].prs));
         check($sformatf("vec[%0d] release", i), 32'(rel), 32'(vecs[i].rel));
         @(posedge clk); #1;
         check($sformatf("vec[%0d] pulse 1clk", i), 32'({prs, rel}), 32'(0));
      end

      // Gating and reset mid-pending on ch3
      do_sample(4'b0111);
      do_sample(4'b0111);
      check("ch3 pending", 32'({lvl, prs, rel}), 32'(0));
      repeat (50) @(posedge clk);
      #1;
      check("ch3 gated hold", 32'({lvl, prs, rel}), 32'(0));
      rst = 1'b1;
      @(posedge clk); #1;
      check("ch3 during reset", 32'({lvl, prs, rel}), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      check("ch3 after reset", 32'({lvl, prs, rel}), 32'(0));
      for (int i = 0; i < 3; i++) begin
         do_sample(4'b0111);
         check($sformatf("ch3 post-reset sample %0d", i + 1), 32'({lvl, prs, rel}), 32'(0));
      end
      do_sample(4'b0111);
      check("ch3 accept level", 32'(lvl), 32'(4'b1000));
      check("ch3 accept press", 32'({prs, rel}), 32'({4'b1000, 4'b0000}));

      // Latency sweep with continuous strobe
      sen_s = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("sweep idle", 32'({lvl1, prs1, rel1, lvl8, prs8, rel8}), 32'(0));
      measure(1, 8'h00, 8'h01, 8'h01, 8'h00, 1 + SYNC_LAT, "n1 press");
      measure(1, 8'h01, 8'h00, 8'h00, 8'h01, 1 + SYNC_LAT, "n1 release");
      measure(8, 8'hA5, 8'h5A, 8'h5A, 8'h00, 16 + SYNC_LAT, "n8 press");
      measure(8, 8'hFF, 8'h00, 8'h00, 8'h5A, 16 + SYNC_LAT, "n8 release");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel push-button debouncer, the successor to the single-channel 4-sample shift-register debouncer.
- Runs on the fast system clock; a sample-enable strobe (e.g. 100 Hz tick from a prescaler) sets the sampling rate.
- Per channel: a consecutive-sample counter of configurable depth, a debounced level, and one-cycle press/release pulses for downstream FSMs (menu, counter, keypad logic).

Parameters:
- NUM_CH, 4, number of independent button channels (1..32).
- STABLE_CNT, 4, consecutive differing samples required to accept a change (1..255).
- INVERT, 1, 1 = buttons are active-low at the pin (raw = ~pb_in); 0 = active-high.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sample_en  input  1  one-clk-cycle sampling strobe; channels update only when high.
- pb_in  input  NUM_CH  raw button inputs, bit i = channel i.
- pb_level  output  NUM_CH  debounced level, 1 = pressed.
- pb_press  output  NUM_CH  one-clk-cycle pulse on accepted 0->1 of pb_level.
- pb_release  output  NUM_CH  one-clk-cycle pulse on accepted 1->0 of pb_level.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); all state updates on posedge clk only.
- Reset values: pb_level = 0, pb_press = 0, pb_release = 0, every channel counter = 0, and sync flops = 0 (or 1 when INVERT = 1, so the idle pin state does not register as a press).
- Definitions: raw_i = pb_in[i] XOR INVERT (after the synchroniser, if enabled). Counter width = $clog2(STABLE_CNT+1).
- Per-channel states (implicit in the counter):
  - STABLE: cnt = 0.
  - PENDING: 0 < cnt < STABLE_CNT.
- Per-channel transitions, on a clk edge with sample_en = 1:
  - raw_i == pb_level[i]: cnt <= 0 (any pending change is abandoned).
  - raw_i != pb_level[i] and cnt == STABLE_CNT-1: pb_level[i] <= raw_i, cnt <= 0, and the matching press/release pulse is asserted for this cycle.
  - raw_i != pb_level[i] otherwise: cnt <= cnt+1.
- sample_en = 0: cnt and pb_level hold; pb_press and pb_release are 0.
- Pulses are registered and asserted in the same cycle pb_level changes. They are never high for two consecutive clk cycles, even if sample_en stays high continuously.
- Latency: pb_level changes on the clk edge of the STABLE_CNT-th consecutive differing sample, plus 2 clk when the synchroniser is enabled.
- STABLE_CNT = 1: change accepted on the first differing sample.
- A glitch shorter than STABLE_CNT samples produces no change and no pulse; the counter restarts from 0 on the next differing sample.
- Channels are fully independent. Simultaneous acceptance on several channels in one cycle asserts all of the corresponding pulse bits.
- Reset asserted mid-PENDING clears the counter; no pulse is emitted during or at release of reset.
- Counter never exceeds STABLE_CNT-1, so it cannot wrap.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined: each pb_in bit passes through a 2-flop synchroniser clocked on clk before use. Latency +2 clk. Sync flops reset to the INVERT value.
- Undefined: pb_in is used directly; the caller guarantees inputs are synchronous to clk.

Decomposition:
- Shared package debounce_pkg:
  - DB_MAX_CH = 32 and DB_MAX_STABLE = 255.
  - Function computing counter width from STABLE_CNT.
- Sub-module debounce_channel: one channel (synchroniser, counter, level, press/release registers). debounce_multi instantiates it NUM_CH times via generate.

Test Plan:
- Reset then idle: rst high 3 clk, pb_in = 4'b1111 (INVERT = 1), sample_en every 10 clk, 200 clk -> pb_level = 0; press, release and pb_level never assert.
- Clean press: ch0 held low for 6 samples -> pb_level[0] rises on the 4th sample edge, pb_press[0] high exactly 1 clk, other channels unchanged.
- Bounce: ch1 pattern low, low, high, low, low, low, low (one per sample) -> no change until the 4th consecutive low, i.e. the 7th sample; exactly one pb_press[1] pulse.
- Release with simultaneous events: ch0 and ch2 both pressed, then both released on the same sample -> pb_release = 4'b0101 in one cycle, pb_level = 0 afterwards.
- Sample gating and reset mid-pending: ch3 low for 2 samples, sample_en held 0 for 50 clk, rst pulsed 1 clk, then 3 more low samples -> no pulse (counter cleared); 4th low sample sets pb_level[3].
- Parameter sweep: NUM_CH = 1 with STABLE_CNT = 1, and NUM_CH = 8 with STABLE_CNT = 16, with and without DEBOUNCE_SYNC_EN -> latency matches STABLE_CNT samples (+2 clk when the synchroniser is enabled).
